// File: rtl/mysum_pipe.sv
// Pipelined signed term summer: registered binary adder tree with valid tracking,
// global stall via clock enable, and wrap-or-saturate conversion into the output register.
module mysum_pipe #(
  parameter int in_bits  = 8,
  parameter int in_terms = 4,
  parameter int out_bits = 8,
  parameter bit saturate = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic signed [in_bits-1:0]  in [in_terms],
  input  logic                       in_valid,
  output logic signed [out_bits-1:0] out,
  output logic                       out_valid,
  output logic                       out_ovf
);

  localparam int LOG_T = $clog2(in_terms);
  localparam int W     = in_bits + LOG_T;
  localparam int L     = (LOG_T > 1) ? LOG_T : 1;
  localparam int RL    = (L > 1) ? L - 1 : 1;
  // Comparison domain wide enough to hold both the sum and the output range bounds.
  localparam int XW    = (W > out_bits) ? W : out_bits + 1;
  localparam logic signed [XW-1:0] MAX_X = {{(XW-out_bits+1){1'b0}}, {(out_bits-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_X = {{(XW-out_bits+1){1'b1}}, {(out_bits-1){1'b0}}};

  logic signed [W-1:0]        tree_q [RL][in_terms];
  logic signed [W-1:0]        tree_d [RL][in_terms];
  logic signed [W-1:0]        root_s;
  logic [L-1:0]               vld_q;
  logic [L-1:0]               vld_d;
  logic signed [out_bits-1:0] out_q;
  logic signed [out_bits-1:0] out_d;
  logic                       ovf_q;
  logic                       ovf_d;

  // Returns {overflow, converted value} for a full-precision sum.
  function automatic logic [out_bits:0] convert(input logic signed [W-1:0] sum);
    logic signed [XW-1:0]       sx;
    logic                       ovf;
    logic signed [out_bits-1:0] res;
    sx  = XW'(sum);
    ovf = (sx > MAX_X) || (sx < MIN_X);
    if (saturate && ovf) begin
      if (sx > MAX_X) begin
        res = out_bits'(MAX_X);
      end else begin
        res = out_bits'(MIN_X);
      end
    end else begin
      res = out_bits'(sx);
    end
    return {ovf, res};
  endfunction

  // Pairwise sums for every tree level; the last level feeds the output conversion.
  always_comb begin
    logic signed [W-1:0] cur [in_terms];
    logic signed [W-1:0] nxt [in_terms];
    int cnt;
    int src;
    int dst;
    int a;
    int b;
    tree_d = tree_q;
    root_s = '0;
    cnt    = in_terms;
    for (int k = 0; k < L; k++) begin
      src = (k > 0) ? k - 1 : 0;
      dst = (k < RL) ? k : 0;
      for (int j = 0; j < in_terms; j++) begin
        if (k == 0) begin
          cur[j] = W'(in[j]);
        end else begin
          cur[j] = tree_q[src][j];
        end
      end
      for (int j = 0; j < in_terms; j++) begin
        a = (2 * j < in_terms) ? 2 * j : 0;
        b = (2 * j + 1 < in_terms) ? 2 * j + 1 : 0;
        if (2 * j + 1 < cnt) begin
          nxt[j] = cur[a] + cur[b];
        end else if (2 * j < cnt) begin
          nxt[j] = cur[a];
        end else begin
          nxt[j] = '0;
        end
      end
      cnt = (cnt + 1) / 2;
      if (k < L - 1) begin
        tree_d[dst] = nxt;
      end else begin
        root_s = nxt[0];
      end
    end
  end

  // Valid shift register next state and output conversion.
  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = in_valid;
    for (int i = 1; i < L; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    {ovf_d, out_d} = convert(root_s);
  end

  // Pipeline registers: reset dominates, ce=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RL; k++) begin
        for (int j = 0; j < in_terms; j++) begin
          tree_q[k][j] <= '0;
        end
      end
      vld_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (ce) begin
      tree_q <= tree_d;
      vld_q  <= vld_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q[L-1];
  assign out_ovf   = ovf_q;

endmodule
